// File: rtl/updown_cnt_pkg.sv
// Shared definitions for the up/down modulo counter.
//   DIR_UP / DIR_DN : encoding of the up_dn input.
//   next_count()    : one count step computed in CNT_XW bits (WIDTH+1 or wider).
//                     Supported counter widths are 1..CNT_MAXW.
//                     The caller zero-extends its count into CNT_XW bits and uses the low WIDTH bits.
package updown_cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest counter the step function supports. One extra bit of headroom lets
  // a modulus of 2**WIDTH be represented, so the top of range is computed without truncation.
  localparam int CNT_MAXW = 32;
  localparam int CNT_XW   = CNT_MAXW + 1;

  localparam logic [CNT_XW-1:0] ONE_X  = CNT_XW'(1);
  localparam logic [CNT_XW-1:0] ZERO_X = '0;

  // Step the count by one in direction up_dn within 0..mod-1.
  // sat=1 holds at the end of the range instead of wrapping.
  function automatic logic [CNT_XW-1:0] next_count(
    input logic [CNT_XW-1:0] count,
    input logic              up_dn,
    input logic [CNT_XW-1:0] mod,
    input logic              sat
  );
    logic [CNT_XW-1:0] res;
    res = count;
    if (up_dn == DIR_UP) begin
      if (count == mod - ONE_X) res = sat ? count : ZERO_X;
      else                      res = count + ONE_X;
    end else if (up_dn == DIR_DN) begin
      if (count == ZERO_X)      res = sat ? count : mod - ONE_X;
      else                      res = count - ONE_X;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnt_step.sv
// Combinational next-state logic for updown_mod_counter.
// Build option: define UPDOWN_CNT_SATURATE_EN to hold at the range ends
// instead of wrapping (load clamping is the same in both builds).
// Ports:
//   count     in   WIDTH  current registered count
//   up_dn     in   1      1 = up, 0 = down
//   en        in   1      count enable
//   load      in   1      parallel load request (overrides en)
//   load_val  in   WIDTH  load value, clamped to MOD-1
//   nxt       out  WIDTH  value the count register takes on the next edge
//   tc        out  1      terminal count: next edge wraps (or saturates)
module cnt_step
  import updown_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  localparam logic [CNT_XW-1:0] MOD_X = CNT_XW'(MOD);

`ifdef UPDOWN_CNT_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic [CNT_XW-1:0] cnt_x;
  logic [CNT_XW-1:0] lval_x;
  logic [CNT_XW-1:0] step_x;
  logic [CNT_XW-1:0] nxt_x;
  logic              at_end;
  logic              unused_hi;

  always_comb begin
    cnt_x               = '0;
    cnt_x[WIDTH-1:0]    = count;
    lval_x              = '0;
    lval_x[WIDTH-1:0]   = load_val;

    at_end = (up_dn == DIR_UP) ? (cnt_x == MOD_X - ONE_X) : (cnt_x == ZERO_X);
    tc     = en & ~load & at_end;

    step_x = next_count(cnt_x, up_dn, MOD_X, SAT);

    if (load) begin
      // Out-of-range load values clamp to the top of the range.
      nxt_x = (lval_x >= MOD_X) ? (MOD_X - ONE_X) : lval_x;
    end else if (en) begin
      nxt_x = step_x;
    end else begin
      nxt_x = cnt_x;
    end
  end

  assign nxt = nxt_x[WIDTH-1:0];

  // Upper bits are always zero because every result is < MOD <= 2**WIDTH.
  assign unused_hi = ^nxt_x[CNT_XW-1:WIDTH];

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with enable, parallel load,
// terminal-count flag and a registered wrap pulse.
// Build option: UPDOWN_CNT_SATURATE_EN selects saturating instead of wrapping
// (see cnt_step); wrap then marks a saturation hit.
// Parameters: WIDTH (1..32), MOD (2..2**WIDTH), RST_VAL (< MOD).
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-high reset
//   en        in   1      count enable
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous load (priority over en)
//   load_val  in   WIDTH  load value
//   count     out  WIDTH  registered count
//   tc        out  1      terminal count (combinational)
//   wrap      out  1      one-cycle pulse following a tc edge
module updown_mod_counter
  import updown_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MOD     = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] nxt;

  cnt_step #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_step (
    .count    (count),
    .up_dn    (up_dn),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .nxt      (nxt),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= WIDTH'(RST_VAL);
      wrap  <= 1'b0;
    end else begin
      count <= nxt;
      // tc is already gated by en and load, so this covers hold and load edges.
      wrap  <= tc;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MOD     = 10;
  localparam int RST_VAL = 0;

  logic             clk;
  logic             reset;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  int n_tests;
  int n_fail;

  // Reference model state: plain integers, advanced by arithmetic on the rules.
  int m_cnt;
  int m_nxt;
  bit m_tc;
  bit m_wrap;

  updown_mod_counter #(
    .WIDTH   (WIDTH),
    .MOD     (MOD),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic int m_step(int c, bit u);
`ifdef UPDOWN_CNT_SATURATE_EN
    if (u && c == MOD - 1) return c;
    if (!u && c == 0) return c;
`endif
    return u ? (c + 1) % MOD : (c + MOD - 1) % MOD;
  endfunction

  // Drive inputs and compute what the model expects for tc and the next count.
  task automatic apply(bit e, bit u, bit l, int v);
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = WIDTH'(v);
    m_tc     = e && !l && (u ? (m_cnt == MOD - 1) : (m_cnt == 0));
    if (l)      m_nxt = (v >= MOD) ? MOD - 1 : v;
    else if (e) m_nxt = m_step(m_cnt, u);
    else        m_nxt = m_cnt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_cnt  = m_nxt;
    m_wrap = m_tc;
    #1;
  endtask

  task automatic test_reset();
    // Park at 7, then assert reset between edges.
    apply(0, 1, 1, 7);
    tick();
    apply(1, 1, 0, 0);
    #20;
    reset = 1'b1;
    #1;
    m_cnt = RST_VAL; m_wrap = 1'b0;
    n_tests++;
    if (count !== WIDTH'(RST_VAL)) begin
      n_fail++; $display("FAIL reset_async_count: got %0d want %0d", count, RST_VAL);
    end
    n_tests++;
    if (wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_wrap: got %0b want 0", wrap);
    end
    @(posedge clk); #1;
    n_tests++;
    if (count !== WIDTH'(RST_VAL)) begin
      n_fail++; $display("FAIL reset_held_count: got %0d want %0d", count, RST_VAL);
    end
    #20;
    reset = 1'b0;
    apply(0, 1, 0, 0);
  endtask

  task automatic test_count_up();
    int exp_c [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int prev;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      apply(1, 1, 0, 0);
      n_tests++;
      if (tc !== (prev == 9)) begin
        n_fail++; $display("FAIL up_tc[%0d]: got %0b want %0b", i, tc, prev == 9);
      end
      tick();
      n_tests++;
      if (count !== WIDTH'(exp_c[i]) || wrap !== (i == 9)) begin
        n_fail++;
        $display("FAIL up_step[%0d]: got count=%0d wrap=%0b want count=%0d wrap=%0b",
                 i, count, wrap, exp_c[i], i == 9);
      end
      prev = exp_c[i];
    end
  endtask

  task automatic test_count_down();
    int exp_c [4] = '{1, 0, 9, 8};
    int prev;
    prev = 2;
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0);
      n_tests++;
      if (tc !== (prev == 0)) begin
        n_fail++; $display("FAIL dn_tc[%0d]: got %0b want %0b", i, tc, prev == 0);
      end
      tick();
      n_tests++;
      if (count !== WIDTH'(exp_c[i]) || wrap !== (i == 2)) begin
        n_fail++;
        $display("FAIL dn_step[%0d]: got count=%0d wrap=%0b want count=%0d wrap=%0b",
                 i, count, wrap, exp_c[i], i == 2);
      end
      prev = exp_c[i];
    end
  endtask

  task automatic test_load_clamp();
    apply(1, 1, 1, 13);
    n_tests++;
    if (tc !== 1'b0) begin
      n_fail++; $display("FAIL load_tc: got %0b want 0", tc);
    end
    tick();
    n_tests++;
    if (count !== 4'd9 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_clamp: got count=%0d wrap=%0b want count=9 wrap=0", count, wrap);
    end
    // At 9 with en=1 up, load still wins: no wrap.
    apply(1, 1, 1, 4);
    tick();
    n_tests++;
    if (count !== 4'd4 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_4: got count=%0d wrap=%0b want count=4 wrap=0", count, wrap);
    end
  endtask

  task automatic test_en_toggle();
`ifdef UPDOWN_CNT_SATURATE_EN
    int exp_c [4] = '{9, 9, 9, 9};
`else
    int exp_c [4] = '{9, 9, 0, 0};
`endif
    bit exp_w [4] = '{0, 0, 1, 0};
    apply(0, 1, 1, 8);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(i % 2 == 0, 1, 0, 0);
      tick();
      n_tests++;
      if (count !== WIDTH'(exp_c[i]) || wrap !== exp_w[i]) begin
        n_fail++;
        $display("FAIL en_toggle[%0d]: got count=%0d wrap=%0b want count=%0d wrap=%0b",
                 i, count, wrap, exp_c[i], exp_w[i]);
      end
    end
  endtask

`ifdef UPDOWN_CNT_SATURATE_EN
  task automatic test_saturate();
    apply(0, 1, 1, 8);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 0, 0);
      n_tests++;
      if (tc !== (i != 0)) begin
        n_fail++; $display("FAIL sat_tc[%0d]: got %0b want %0b", i, tc, i != 0);
      end
      tick();
      n_tests++;
      if (count !== 4'd9 || wrap !== (i != 0)) begin
        n_fail++;
        $display("FAIL sat_step[%0d]: got count=%0d wrap=%0b want count=9 wrap=%0b",
                 i, count, wrap, i != 0);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit e, u, l;
    int v;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      l = ($urandom_range(0, 9) == 0);
      v = $urandom_range(0, 15);
      apply(e, u, l, v);
      n_tests++;
      if (tc !== m_tc) begin
        n_fail++; $display("FAIL rand_tc[%0d]: got %0b want %0b", i, tc, m_tc);
      end
      tick();
      n_tests++;
      if (count !== WIDTH'(m_cnt) || wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL rand_step[%0d]: got count=%0d wrap=%0b want count=%0d wrap=%0b",
                 i, count, wrap, m_cnt, m_wrap);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    m_cnt    = RST_VAL;
    m_nxt    = RST_VAL;
    m_tc     = 1'b0;
    m_wrap   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (count !== WIDTH'(RST_VAL) || wrap !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d wrap=%0b tc=%0b want count=%0d wrap=0 tc=0",
               count, wrap, tc, RST_VAL);
    end
    #20;
    reset = 1'b0;
    tick();
    test_reset();
`ifndef UPDOWN_CNT_SATURATE_EN
    test_count_up();
    test_count_down();
`else
    test_saturate();
`endif
    test_load_clamp();
    test_en_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
